// File: rtl/pc_fetch_reg.sv
// Program counter and IF/ID pipeline register for the pipelined SAD datapath.
// Redirect (taken branch/jump) overrides stalls on the PC and flushes IF/ID to a bubble.
module pc_fetch_reg #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [31:0]            NextPC,
  input  logic                   Redirect,
  input  logic                   PCWrite,
  input  logic                   IFIDWrite,
  input  logic [31:0]            Instruction,
  output logic [31:0]            PC,
  output logic [31:0]            PCPlus4,
  output logic [31:0]            IFID_Instruction,
  output logic [31:0]            IFID_PCPlus4,
  output logic                   IFID_Valid,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic pc_load;
  logic stall_cycle;
  logic cnt_full;

  // The two enables act independently; the hazard unit is expected to drop both together.
  assign pc_load     = Redirect | PCWrite;
  assign stall_cycle = ~PCWrite & ~Redirect;
  assign cnt_full    = &StallCount;

  assign PCPlus4 = PC + 32'd4;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PC <= RESET_PC;
    end else if (pc_load) begin
      PC <= NextPC;
    end
  end

  // Flush wins over the write enable so a redirect always leaves exactly one bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      IFID_Instruction <= 32'd0;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (Redirect) begin
      IFID_Instruction <= 32'd0;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (IFIDWrite) begin
      IFID_Instruction <= Instruction;
      IFID_PCPlus4     <= PCPlus4;
      IFID_Valid       <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
    end else if (stall_cycle && !cnt_full) begin
      StallCount <= StallCount + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Bench for pc_fetch_reg: a default-width and a 4-bit-counter instance share one stimulus
// stream and are compared every cycle against a fetch-stage model plus literal checkpoints.
module tb_pc_fetch_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'd0;
  logic        redirect = 1'b0;
  logic        pc_write = 1'b0;
  logic        ifid_write = 1'b0;
  logic [31:0] instruction = 32'd0;

  logic [31:0] pc_a, pc_plus4_a, ifid_instr_a, ifid_pc4_a;
  logic        ifid_valid_a;
  logic [15:0] stall_cnt_a;
  logic [31:0] pc_b, pc_plus4_b, ifid_instr_b, ifid_pc4_b;
  logic        ifid_valid_b;
  logic [3:0]  stall_cnt_b;

  int checks = 0;
  int failures = 0;

  // model state; stall count kept unsaturated and clipped per instance width
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;
  int          m_stalls = 0;

  always #5 clk = ~clk;

  pc_fetch_reg dut_a (
    .Clk(clk), .Rst_n(rst_n), .NextPC(next_pc), .Redirect(redirect),
    .PCWrite(pc_write), .IFIDWrite(ifid_write), .Instruction(instruction),
    .PC(pc_a), .PCPlus4(pc_plus4_a), .IFID_Instruction(ifid_instr_a),
    .IFID_PCPlus4(ifid_pc4_a), .IFID_Valid(ifid_valid_a), .StallCount(stall_cnt_a)
  );

  pc_fetch_reg #(.RESET_PC(32'h0000_0000), .STALL_CNT_W(4)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .NextPC(next_pc), .Redirect(redirect),
    .PCWrite(pc_write), .IFIDWrite(ifid_write), .Instruction(instruction),
    .PC(pc_b), .PCPlus4(pc_plus4_b), .IFID_Instruction(ifid_instr_b),
    .IFID_PCPlus4(ifid_pc4_b), .IFID_Valid(ifid_valid_b), .StallCount(stall_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'd0;
    m_instr  = 32'd0;
    m_pc4    = 32'd0;
    m_valid  = 1'b0;
    m_stalls = 0;
  endtask

  function automatic logic [31:0] clip(input int n, input int maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  task automatic compare_all();
    check("a.pc",         pc_a,                 m_pc);
    check("a.pc_plus4",   pc_plus4_a,           m_pc + 32'd4);
    check("a.ifid_instr", ifid_instr_a,         m_instr);
    check("a.ifid_pc4",   ifid_pc4_a,           m_pc4);
    check("a.ifid_valid", 32'(ifid_valid_a),    32'(m_valid));
    check("a.stall_cnt",  32'(stall_cnt_a),     clip(m_stalls, 65535));
    check("b.pc",         pc_b,                 m_pc);
    check("b.ifid_instr", ifid_instr_b,         m_instr);
    check("b.ifid_valid", 32'(ifid_valid_b),    32'(m_valid));
    check("b.stall_cnt",  32'(stall_cnt_b),     clip(m_stalls, 15));
  endtask

  always @(negedge rst_n) model_reset();

  // model advance and per-cycle compare
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      if (redirect) begin
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
      end else if (ifid_write) begin
        m_instr = instruction;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      if (!pc_write && !redirect) m_stalls++;
      if (redirect || pc_write) m_pc = next_pc;
    end
    #1 compare_all();
  end

  task automatic drive(input logic r, input logic pw, input logic iw, input logic [31:0] npc);
    redirect    = r;
    pc_write    = pw;
    ifid_write  = iw;
    next_pc     = npc;
    instruction = 32'hA000_0000 + m_pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch();
    drive(1'b0, 1'b1, 1'b1, m_pc + 32'd4);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("lit.reset_pc",     pc_a, 32'd0);
    check("lit.reset_pc4",    pc_plus4_a, 32'd4);
    check("lit.reset_valid",  32'(ifid_valid_a), 32'd0);
    check("lit.reset_cnt",    32'(stall_cnt_a), 32'd0);
    rst_n = 1'b1;

    fetch();
    check("lit.f1_pc",    pc_a, 32'd4);
    check("lit.f1_instr", ifid_instr_a, 32'hA000_0000);
    check("lit.f1_pc4",   ifid_pc4_a, 32'd4);
    fetch();
    check("lit.f2_pc",    pc_a, 32'd8);
    check("lit.f2_instr", ifid_instr_a, 32'hA000_0004);
    check("lit.f2_valid", 32'(ifid_valid_a), 32'd1);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0000_0DEC);
    check("lit.stall_pc",    pc_a, 32'd8);
    check("lit.stall_instr", ifid_instr_a, 32'hA000_0004);
    check("lit.stall_cnt",   32'(stall_cnt_a), 32'd3);
    fetch();
    check("lit.resume_pc", pc_a, 32'd12);
    check("lit.resume_pc4", ifid_pc4_a, 32'd12);
    fetch();
    check("lit.resume2_pc", pc_a, 32'd16);
    check("lit.resume2_instr", ifid_instr_a, 32'hA000_000C);

    drive(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    check("lit.redir_pc",    pc_a, 32'h100);
    check("lit.redir_instr", ifid_instr_a, 32'd0);
    check("lit.redir_valid", 32'(ifid_valid_a), 32'd0);
    check("lit.redir_cnt",   32'(stall_cnt_a), 32'd3);
    fetch();
    check("lit.target_instr", ifid_instr_a, 32'hA000_0100);
    check("lit.target_pc4",   ifid_pc4_a, 32'h104);

    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("lit.wrap_pc4", pc_plus4_a, 32'd0);
    fetch();
    check("lit.wrap_pc",    pc_a, 32'd0);
    check("lit.wrap_instr", ifid_instr_a, 32'h9FFF_FFFC);
    check("lit.wrap_ifpc4", ifid_pc4_a, 32'd0);

    drive(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    check("lit.pc_only_instr", ifid_instr_a, 32'h9FFF_FFFC);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    check("lit.ifid_only_pc",    pc_a, 32'h200);
    check("lit.ifid_only_instr", ifid_instr_a, 32'hA000_0200);
    check("lit.ifid_only_cnt",   32'(stall_cnt_a), 32'd4);

    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
    check("lit.sat_small", 32'(stall_cnt_b), 32'hF);
    check("lit.sat_big",   32'(stall_cnt_a), 32'd24);

    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check("lit.pre_rst_pc", pc_a, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("lit.async_pc",    pc_a, 32'd0);
    check("lit.async_pc4",   pc_plus4_a, 32'd4);
    check("lit.async_valid", 32'(ifid_valid_a), 32'd0);
    check("lit.async_cnt_a", 32'(stall_cnt_a), 32'd0);
    check("lit.async_cnt_b", 32'(stall_cnt_b), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0500);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    fetch();
    check("lit.post_rst_pc",    pc_a, 32'd4);
    check("lit.post_rst_instr", ifid_instr_a, 32'hA000_0000);
    check("lit.post_rst_valid", 32'(ifid_valid_a), 32'd1);
    check("lit.post_rst_cnt",   32'(stall_cnt_a), 32'd0);
    fetch();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
